// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/FLUSH/HALT Moore FSM selecting PC+4, branch or JALR target.
// Latency: pc and state update one clk after the deciding inputs; fetch_en reacts to stall in the same cycle.
// Backpressure: stall holds pc and drops fetch_en in RUN; a redirect inserts FLUSH_CYCLES bubble cycles.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2  // legal range 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic        sel_valid,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        fetch_en,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misaligned_err,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t      cur_st, nxt_st;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        redirect;
  logic [31:0] tgt;
  logic [31:0] jalr_aligned;

  // JALR targets always have bit 0 cleared; sel=11 is reserved and never redirects.
  always_comb begin
    jalr_aligned = jalr_target & ~32'h0000_0001;
    redirect     = sel_valid && ((sel == 2'b01) || (sel == 2'b10));
    tgt          = branch_target;
    if (sel == 2'b10) begin
      tgt = jalr_aligned;
    end
  end

  // Next-state and output decode; RUN priority is halt_req > redirect > stall > increment.
  always_comb begin
    nxt_st     = cur_st;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    fetch_en   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    case (cur_st)
      ST_RUN: begin
        fetch_en = 1'b1;
        if (halt_req) begin
          nxt_st = ST_HALT;
        end else if (redirect) begin
          if (tgt[1]) begin
            // Target not word aligned: park in HALT with the faulting pc still visible.
            err_d  = 1'b1;
            nxt_st = ST_HALT;
          end else begin
            pc_d   = tgt;
            cnt_d  = FLUSH_LOAD;
            nxt_st = ST_FLUSH;
          end
        end else if (stall) begin
          fetch_en = 1'b0;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_FLUSH: begin
        // Wrong-path cycles: sel_valid and stall are deliberately ignored here.
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        if (halt_req) begin
          cnt_d  = 3'd0;
          nxt_st = ST_HALT;
        end else if (cnt_q <= 3'd1) begin
          cnt_d  = 3'd0;
          nxt_st = ST_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_HALT: begin
        if (resume && !halt_req) begin
          err_d  = 1'b0;
          nxt_st = ST_RUN;
        end
      end
      default: begin
        // Unused encoding 2'b11: recover to RUN.
        nxt_st = ST_RUN;
      end
    endcase
  end

  // State, pc, flush counter and sticky error registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_st <= ST_RUN;
      pc_q   <= RESET_PC;
      cnt_q  <= 3'd0;
      err_q  <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign pc             = pc_q;
  assign misaligned_err = err_q;
  assign state          = cur_st;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus a hand-written wrap/flush-length sequence.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later, before the next rising edge.
// Second instance uses RESET_PC=32'hFFFF_FFF8 and FLUSH_CYCLES=3.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [1:0]  sel;
  logic        sel_valid;
  logic [31:0] branch_target;
  logic [31:0] jalr_target;
  logic        stall;
  logic        halt_req;
  logic        resume;

  logic [31:0] pc;
  logic        fetch_en, flush_ifid, flush_idex, misaligned_err;
  logic [1:0]  state;

  logic [31:0] pc_w;
  logic        fetch_en_w, flush_ifid_w, flush_idex_w, misaligned_err_w;
  logic [1:0]  state_w;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .sel(sel), .sel_valid(sel_valid),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .stall(stall), .halt_req(halt_req), .resume(resume),
    .pc(pc), .fetch_en(fetch_en), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .misaligned_err(misaligned_err), .state(state)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(3)) dut_w (
    .clk(clk), .rst(rst), .sel(sel), .sel_valid(sel_valid),
    .branch_target(branch_target), .jalr_target(jalr_target),
    .stall(stall), .halt_req(halt_req), .resume(resume),
    .pc(pc_w), .fetch_en(fetch_en_w), .flush_ifid(flush_ifid_w), .flush_idex(flush_idex_w),
    .misaligned_err(misaligned_err_w), .state(state_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic        sv;
    logic [31:0] bt;
    logic [31:0] jt;
    logic        stall;
    logic        hr;
    logic        rs;
    logic [31:0] epc;
    logic        efe;
    logic        efi;
    logic        efx;
    logic        eerr;
    logic [1:0]  est;
  } vec_t;

  localparam int NV = 35;
  vec_t tbl[NV];

  function automatic vec_t mk(logic r, logic [1:0] s, logic v, logic [31:0] b, logic [31:0] j,
                              logic st, logic h, logic rs, logic [31:0] p, logic fe,
                              logic fi, logic fx, logic er, logic [1:0] sta);
    vec_t t;
    t.rst = r; t.sel = s; t.sv = v; t.bt = b; t.jt = j; t.stall = st; t.hr = h; t.rs = rs;
    t.epc = p; t.efe = fe; t.efi = fi; t.efx = fx; t.eerr = er; t.est = sta;
    return t;
  endfunction

  task automatic drive(logic r, logic [1:0] s, logic v, logic [31:0] b, logic [31:0] j,
                       logic st, logic h, logic rs);
    rst = r; sel = s; sel_valid = v; branch_target = b; jalr_target = j;
    stall = st; halt_req = h; resume = rs;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    // Row: inputs applied this cycle, then outputs expected before the next rising edge.
    //            rst sel    sv bt            jt            st h  rs   pc            fe fi fx er st
    tbl[0]  = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h000, 1, 0, 0, 0, 2'b00);
    tbl[1]  = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h004, 1, 0, 0, 0, 2'b00);
    tbl[2]  = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h008, 1, 0, 0, 0, 2'b00);
    tbl[3]  = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h00C, 1, 0, 0, 0, 2'b00);
    tbl[4]  = mk(1, 2'b01, 1, 32'h100,     32'h0,       1, 0, 0, 32'h010, 1, 0, 0, 0, 2'b00);
    tbl[5]  = mk(1, 2'b10, 1, 32'h0,       32'h400,     1, 0, 0, 32'h100, 0, 1, 1, 0, 2'b01);
    tbl[6]  = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h100, 0, 1, 1, 0, 2'b01);
    tbl[7]  = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h100, 1, 0, 0, 0, 2'b00);
    tbl[8]  = mk(1, 2'b00, 0, 32'h0,       32'h0,       1, 0, 0, 32'h104, 0, 0, 0, 0, 2'b00);
    tbl[9]  = mk(1, 2'b00, 0, 32'h0,       32'h0,       1, 0, 1, 32'h104, 0, 0, 0, 0, 2'b00);
    tbl[10] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h104, 1, 0, 0, 0, 2'b00);
    tbl[11] = mk(1, 2'b10, 1, 32'h0,       32'h203,     0, 0, 0, 32'h108, 1, 0, 0, 0, 2'b00);
    tbl[12] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h108, 0, 0, 0, 1, 2'b10);
    tbl[13] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 1, 1, 32'h108, 0, 0, 0, 1, 2'b10);
    tbl[14] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 1, 32'h108, 0, 0, 0, 1, 2'b10);
    tbl[15] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h108, 1, 0, 0, 0, 2'b00);
    tbl[16] = mk(1, 2'b11, 1, 32'h500,     32'h600,     0, 0, 0, 32'h10C, 1, 0, 0, 0, 2'b00);
    tbl[17] = mk(1, 2'b01, 0, 32'h700,     32'h0,       0, 0, 0, 32'h110, 1, 0, 0, 0, 2'b00);
    tbl[18] = mk(1, 2'b10, 1, 32'h0,       32'h301,     0, 0, 0, 32'h114, 1, 0, 0, 0, 2'b00);
    tbl[19] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 1, 0, 32'h300, 0, 1, 1, 0, 2'b01);
    tbl[20] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h300, 0, 0, 0, 0, 2'b10);
    tbl[21] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 1, 32'h300, 0, 0, 0, 0, 2'b10);
    tbl[22] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h300, 1, 0, 0, 0, 2'b00);
    tbl[23] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 1, 0, 32'h304, 1, 0, 0, 0, 2'b00);
    tbl[24] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h304, 0, 0, 0, 0, 2'b10);
    tbl[25] = mk(0, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h304, 0, 0, 0, 0, 2'b10);
    tbl[26] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h000, 1, 0, 0, 0, 2'b00);
    tbl[27] = mk(1, 2'b01, 1, 32'h40,      32'h0,       0, 0, 0, 32'h004, 1, 0, 0, 0, 2'b00);
    tbl[28] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h040, 0, 1, 1, 0, 2'b01);
    tbl[29] = mk(0, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h040, 0, 1, 1, 0, 2'b01);
    tbl[30] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h000, 1, 0, 0, 0, 2'b00);
    tbl[31] = mk(1, 2'b01, 1, 32'h102,     32'h0,       1, 0, 0, 32'h004, 1, 0, 0, 0, 2'b00);
    tbl[32] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h004, 0, 0, 0, 1, 2'b10);
    tbl[33] = mk(0, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h004, 0, 0, 0, 1, 2'b10);
    tbl[34] = mk(1, 2'b00, 0, 32'h0,       32'h0,       0, 0, 0, 32'h000, 1, 0, 0, 0, 2'b00);

    // Reset both instances for two edges.
    drive(0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].sel, tbl[i].sv, tbl[i].bt, tbl[i].jt,
            tbl[i].stall, tbl[i].hr, tbl[i].rs);
      #1;
      chk($sformatf("vec%0d {pc,fe,fi,fx,err,st}", i),
          {26'h0, pc, fetch_en, flush_ifid, flush_idex, misaligned_err, state},
          {26'h0, tbl[i].epc, tbl[i].efe, tbl[i].efi, tbl[i].efx, tbl[i].eerr, tbl[i].est});
    end

    // Wrap-around from RESET_PC=FFFF_FFF8 and a three-cycle flush on the second instance.
    @(negedge clk);
    drive(0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    drive(1, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
    #1;
    chk("wrap reset pc", {32'h0, pc_w}, {32'h0, 32'hFFFF_FFF8});
    chk("wrap reset state", {62'h0, state_w}, {62'h0, 2'b00});
    @(negedge clk);
    #1;
    chk("wrap pc1", {32'h0, pc_w}, {32'h0, 32'hFFFF_FFFC});
    @(negedge clk);
    drive(1, 2'b01, 1, 32'h20, 32'h0, 0, 0, 0);
    #1;
    chk("wrap pc2", {32'h0, pc_w}, {32'h0, 32'h0000_0000});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
      #1;
      chk($sformatf("flush3 cycle%0d {pc,fe,fi,fx,st}", k),
          {27'h0, pc_w, fetch_en_w, flush_ifid_w, flush_idex_w, state_w},
          {27'h0, 32'h20, 1'b0, 1'b1, 1'b1, 2'b01});
    end
    @(negedge clk);
    #1;
    chk("flush3 exit {pc,fe,fi,fx,st}",
        {27'h0, pc_w, fetch_en_w, flush_ifid_w, flush_idex_w, state_w},
        {27'h0, 32'h20, 1'b1, 1'b0, 1'b0, 2'b00});
    @(negedge clk);
    #1;
    chk("flush3 next pc", {32'h0, pc_w}, {32'h0, 32'h24});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: FLUSH_CYCLES, 2, bubble cycles after a redirect; legal range 1..7.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-006 Port: sel  input  2  next-PC select from branch control: 00 PC+4, 01 branch target, 10 JALR target, 11 reserved (treated as 00).
REQ-007 Port: sel_valid  input  1  sel and targets are resolved this cycle.
REQ-008 Port: branch_target  input  32  PC-relative target (JAL/Bxx).
REQ-009 Port: jalr_target  input  32  ALU output for JALR.
REQ-010 Port: stall  input  1  hazard stall request from ID.
REQ-011 Port: halt_req  input  1  halt request (ECALL/EBREAK).
REQ-012 Port: resume  input  1  leave HALT.
REQ-013 Port: pc  output  32  registered fetch address.
REQ-014 Port: fetch_en  output  1  instruction memory read enable / IF-ID load enable.
REQ-015 Port: flush_ifid  output  1  kill IF/ID contents.
REQ-016 Port: flush_idex  output  1  kill ID/EX contents.
REQ-017 Port: misaligned_err  output  1  sticky misaligned-target flag.
REQ-018 Port: state  output  2  00 RUN, 01 FLUSH, 10 HALT.

Function
REQ-019 The block SHALL implement a three-state Moore FSM: RUN, FLUSH, HALT; state and pc SHALL be registered.
REQ-020 RUN priority per cycle SHALL be: halt_req > redirect > stall > increment.
REQ-021 Redirect SHALL mean sel_valid=1 and sel in {01,10}; sel=01 selects branch_target, sel=10 selects jalr_target with bit 0 forced to 0.
REQ-022 Redirect with selected target[1]=0: pc <= target next cycle, state -> FLUSH, flush counter loaded with FLUSH_CYCLES.
REQ-023 Redirect with selected target[1]=1: pc held, misaligned_err <= 1, state -> HALT.
REQ-024 Redirect SHALL override a simultaneous stall.
REQ-025 RUN with stall=1 and no redirect/halt: pc held; fetch_en=0 combinationally in that cycle.
REQ-026 RUN otherwise: pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000); fetch_en=1.
REQ-027 FLUSH: flush_ifid=1, flush_idex=1, fetch_en=0, pc held; counter decrements each cycle; exits to RUN in the cycle the counter reaches 1, so FLUSH lasts exactly FLUSH_CYCLES cycles.
REQ-028 FLUSH SHALL ignore sel_valid and stall (wrong-path).
REQ-029 halt_req in FLUSH: state -> HALT next cycle, counter cleared, pc held.
REQ-030 HALT: fetch_en=0, flush outputs 0, pc held.
REQ-031 HALT with resume=1 and halt_req=0: state -> RUN, misaligned_err cleared, pc unchanged; resume with halt_req=1 SHALL stay in HALT.
REQ-032 resume outside HALT SHALL have no effect.
REQ-033 flush_ifid/flush_idex SHALL be 0 in RUN and HALT.

Reset
REQ-034 rst=0 at a clk edge SHALL set pc=RESET_PC, state=RUN, flush counter=0, misaligned_err=0, regardless of current state (including mid-FLUSH or HALT).
REQ-035 With state=RUN after reset, outputs SHALL be fetch_en=1 (stall=0), flush_ifid=0, flush_idex=0.

Verification
REQ-036 Reset, then 3 idle cycles -> pc 0x0, 0x4, 0x8, 0xC; fetch_en=1; state=00.
REQ-037 pc=0x10, sel=01, sel_valid=1, branch_target=0x100, stall=1 -> next pc=0x100, state FLUSH for exactly 2 cycles with both flush outputs high and fetch_en=0, then RUN with pc 0x104 one cycle later.
REQ-038 sel=10, jalr_target=0x203 -> pc=0x202? No: bit0 cleared gives 0x202, bit1=1 -> misaligned_err=1, state HALT, pc held; resume=1 -> RUN, misaligned_err=0, pc unchanged.
REQ-039 RESET_PC=32'hFFFF_FFF8, 2 idle cycles -> pc 0xFFFF_FFFC then 0x0000_0000.
REQ-040 Redirect, then rst=0 in second FLUSH cycle -> pc=RESET_PC, state RUN, flush outputs 0 next cycle; halt_req during FLUSH -> HALT next cycle; halt_req and resume together in HALT -> remains HALT.
